mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit executing MULT, MULTU, DIV and DIVU on the two register-file read operands (Adat, Bdat).

---
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 tb/tb_mul_div_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per clock on operand magnitudes, followed by a sign-fix cycle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] mt_dat,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic                 isDiv_q;
   logic                 negA_q;
   logic                 negB_q;
   logic                 zero_q;
   logic [WIDTH-1:0]     m_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   acc_d;
   logic [WIDTH-1:0]     hi_q;
   logic [WIDTH-1:0]     lo_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 dz_q;

   logic                 isSigned;
   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       remShift;
   logic [WIDTH:0]       diff;
   logic                 negRes;
   logic [2*WIDTH-1:0]   prodFix;
   logic [WIDTH-1:0]     quoFix;
   logic [WIDTH-1:0]     remFix;

   assign isSigned = ~op[0];
   assign magA     = (isSigned && opa[WIDTH-1]) ? -opa : opa;
   assign magB     = (isSigned && opb[WIDTH-1]) ? -opb : opb;

   // acc_q holds {partial product, remaining multiplier} or {remainder, quotient}.
   always_comb begin
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
      remShift = acc_q[2*WIDTH-1:WIDTH-1];
      diff     = remShift - {1'b0, m_q};
      if (!isDiv_q)
         acc_d = {sum, acc_q[WIDTH-1:1]};
      else if (!diff[WIDTH])
         acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         acc_d = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
   end

   // A zero divisor leaves remainder=|dividend|, so negating by the dividend sign restores opa.
   always_comb begin
      negRes  = negA_q ^ negB_q;
      prodFix = negRes ? -acc_q : acc_q;
      quoFix  = negRes ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      remFix  = negA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         isDiv_q <= 1'b0;
         negA_q  <= 1'b0;
         negB_q  <= 1'b0;
         zero_q  <= 1'b0;
         m_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= CALC;
                  busy_q  <= 1'b1;
                  dz_q    <= 1'b0;
                  cnt_q   <= '0;
                  isDiv_q <= op[1];
                  negA_q  <= isSigned & opa[WIDTH-1];
                  negB_q  <= isSigned & opb[WIDTH-1];
                  zero_q  <= op[1] & (opb == '0);
                  if (op[1]) begin
                     m_q   <= magB;
                     acc_q <= {{WIDTH{1'b0}}, magA};
                  end else begin
                     m_q   <= magA;
                     acc_q <= {{WIDTH{1'b0}}, magB};
                  end
               end else begin
                  if (mt_hi) hi_q <= mt_dat;
                  if (mt_lo) lo_q <= mt_dat;
               end
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) state_q <= FIX;
            end
            FIX: begin
               if (isDiv_q) begin
                  hi_q <= remFix;
                  lo_q <= zero_q ? {WIDTH{1'b1}} : quoFix;
               end else begin
                  hi_q <= prodFix[2*WIDTH-1:WIDTH];
                  lo_q <= prodFix[WIDTH-1:0];
               end
               dz_q    <= zero_q;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_mul_div_unit;

   localparam int WIDTH = 32;

   logic              clk    = 1'b0;
   logic              rst    = 1'b0;
   logic              start  = 1'b0;
   logic [1:0]        op     = 2'b00;
   logic [WIDTH-1:0]  opa    = '0;
   logic [WIDTH-1:0]  opb    = '0;
   logic              mt_hi  = 1'b0;
   logic              mt_lo  = 1'b0;
   logic [WIDTH-1:0]  mt_dat = '0;
   logic              busy;
   logic              done;
   logic              div_by_zero;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;

   int                assertCount = 0;
   int                failCount   = 0;
   logic [31:0]       expHi = '0;
   logic [31:0]       expLo = '0;
   logic              expDz = 1'b0;

   mul_div_unit #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .opa         (opa),
      .opb         (opb),
      .mt_hi       (mt_hi),
      .mt_lo       (mt_lo),
      .mt_dat      (mt_dat),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // MIPS semantics from plain integer arithmetic.
   function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eh, output logic [31:0] el, output logic ed);
      longint      sa;
      longint      sb;
      longint      sq;
      longint      sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eh = '0;
      el = '0;
      ed = 1'b0;
      case (o)
         2'b00: begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
         end
         2'b01: begin
            p  = {32'd0, a} * {32'd0, b};
            eh = p[63:32];
            el = p[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               eh = a;
               el = '1;
               ed = 1'b1;
            end else if (o == 2'b10) begin
               sq = sa / sb;
               sr = sa % sb;
               el = sq[31:0];
               eh = sr[31:0];
            end else begin
               el = a / b;
               eh = a % b;
            end
         end
      endcase
   endfunction

   // Each call starts at the next falling edge, so consecutive calls exercise back-to-back starts.
   task automatic applyStimulus(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] nh;
      logic [31:0] nl;
      logic        nd;
      int          lat;
      int          busyCycles;
      logic        stable;
      refModel(o, a, b, nh, nl, nd);
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      opa    = a;
      opb    = b;
      mt_hi  = 1'b1;
      mt_lo  = 1'b1;
      mt_dat = $urandom;
      @(posedge clk);
      #1;
      start = 1'b0;
      mt_hi = 1'b0;
      mt_lo = 1'b0;
      opa   = $urandom;
      opb   = $urandom;
      op    = 2'($urandom);
      checkOutput({name, ".busyAtStart"}, 64'(busy), 64'(1));
      checkOutput({name, ".doneAtStart"}, 64'(done), 64'(0));
      checkOutput({name, ".dzCleared"}, 64'(div_by_zero), 64'(0));
      checkOutput({name, ".startBeatsMt"}, {hi, lo}, {expHi, expLo});
      lat        = 0;
      busyCycles = 0;
      stable     = 1'b1;
      while (lat < 40 && !done) begin
         if (busy) busyCycles++;
         if (hi !== expHi || lo !== expLo) stable = 1'b0;
         start  = 1'($urandom);
         mt_lo  = 1'b1;
         mt_hi  = 1'($urandom);
         mt_dat = $urandom;
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      mt_hi = 1'b0;
      mt_lo = 1'b0;
      expHi = nh;
      expLo = nl;
      expDz = nd;
      checkOutput({name, ".latency"}, 64'(lat), 64'(33));
      checkOutput({name, ".busyCycles"}, 64'(busyCycles), 64'(33));
      checkOutput({name, ".hiloStable"}, 64'(stable), 64'(1));
      checkOutput({name, ".busyLowAtDone"}, 64'(busy), 64'(0));
      checkOutput({name, ".hi"}, 64'(hi), 64'(expHi));
      checkOutput({name, ".lo"}, 64'(lo), 64'(expLo));
      checkOutput({name, ".divByZero"}, 64'(div_by_zero), 64'(expDz));
   endtask

   task automatic applyMove(input logic h, input logic l, input logic [31:0] d);
      @(negedge clk);
      mt_hi  = h;
      mt_lo  = l;
      mt_dat = d;
      @(posedge clk);
      #1;
      mt_hi = 1'b0;
      mt_lo = 1'b0;
      if (h) expHi = d;
      if (l) expLo = d;
      checkOutput("move.hi", 64'(hi), 64'(expHi));
      checkOutput("move.lo", 64'(lo), 64'(expLo));
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic checkAllZero(input string name);
      checkOutput({name, ".busy"}, 64'(busy), 64'(0));
      checkOutput({name, ".done"}, 64'(done), 64'(0));
      checkOutput({name, ".dz"}, 64'(div_by_zero), 64'(0));
      checkOutput({name, ".hi"}, 64'(hi), 64'(0));
      checkOutput({name, ".lo"}, 64'(lo), 64'(0));
   endtask

   initial begin
      #12;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b1;

      applyStimulus("multuMax", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus("multNeg", 2'b00, 32'hFFFF_FFFD, 32'd7);
      applyStimulus("divNeg", 2'b10, 32'hFFFF_FFF9, 32'd2);
      applyStimulus("divu", 2'b11, 32'd100, 32'd7);
      applyStimulus("divMinNeg", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      applyStimulus("divuZero", 2'b11, 32'd5, 32'd0);
      applyStimulus("divNegZero", 2'b10, 32'hFFFF_FFF9, 32'd0);
      applyStimulus("divRemSign", 2'b10, 32'd7, 32'hFFFF_FFFE);
      applyMove(1'b1, 1'b1, 32'hDEAD_BEEF);
      applyMove(1'b0, 1'b1, 32'h1234_5678);
      applyMove(1'b1, 1'b0, 32'hCAFE_F00D);

      // Abort an operation mid-flight with the asynchronous reset.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b00;
      opa   = 32'h0001_2345;
      opb   = 32'h0000_0777;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      checkOutput("preReset.busy", 64'(busy), 64'(1));
      rst = 1'b0;
      #1;
      checkAllZero("midOpReset");
      expHi = '0;
      expLo = '0;
      expDz = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      applyStimulus("afterReset", 2'b00, 32'hFFFF_FFFD, 32'd7);

      for (int i = 0; i < 24; i++) begin
         applyStimulus("random", 2'($urandom), pickOperand(), pickOperand());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
